cp0_unit: RTL

Coprocessor-0 for the five-stage MIPS pipeline: the consumer end of the memory-stage exception fields (ExcCode, delay-slot flag, PC) and the producer of the `Req` flush that every pipeline register obeys. Holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against synchronous exceptions at the M stage, and services `mfc0`/`mtc0`/`eret`. `Req` redirects fetch to the handler and loads 0x0000_4180 into the M-stage PC on the same edge.

---
 rtl/cp0_pkg.sv | 19 +
 rtl/cp0_unit.sv | 78 +++++++
 2 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register indices, exception codes, handler address and field positions
package cp0_pkg;
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;
  localparam logic [4:0] EXC_INT   = 5'd0;
  localparam logic [4:0] EXC_ADEL  = 5'd4;
  localparam logic [4:0] EXC_ADES  = 5'd5;
  localparam logic [4:0] EXC_RI    = 5'd10;
  localparam logic [4:0] EXC_OV    = 5'd12;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int CAUSE_EXC = 2;
  localparam int CAUSE_IP  = 10;
  localparam int CAUSE_BD  = 31;
endpackage

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 (SR/Cause/EPC/PRId), interrupt/exception arbitration at M, Req flush
// Ports: clk, reset (async active-low); M-stage exception inputs pc_M/ExcCode_M/BD_M; HWInt lines;
// mfc0/mtc0/eret interface cp0_addr/cp0_wdata/cp0_we/EXLClr; outputs cp0_rdata, EPC_out, Req.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2021_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_M,
  input  logic [4:0]  ExcCode_M,
  input  logic        BD_M,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_we,
  input  logic        EXLClr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] EPC_out,
  output logic        Req
);
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;
  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_epc_new;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCode_M != 5'd0) & ~r_exl;
  // gated by reset so a live ExcCode_M cannot raise Req while state is held clear
  assign Req       = reset & (w_int_req | w_exc_req);
  // a delay-slot instruction restarts at its branch
  assign w_epc_new = (BD_M ? pc_M - 32'd4 : pc_M) & ~32'd3;
  assign w_sr      = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause   = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'd0};
  assign EPC_out   = r_epc;
  always_comb begin
    cp0_rdata = cp0_addr == REG_SR    ? w_sr    :
                cp0_addr == REG_CAUSE ? w_cause :
                cp0_addr == REG_EPC   ? r_epc   :
                cp0_addr == REG_PRID  ? PRID    : 32'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        r_exl <= 1'b1;
        r_exc <= w_int_req ? EXC_INT : ExcCode_M;
        r_bd  <= BD_M;
        r_epc <= w_epc_new;
      end else begin
        if (cp0_we && cp0_addr == REG_SR) begin
          r_im  <= cp0_wdata[SR_IM_LO +: 6];
          r_exl <= cp0_wdata[SR_EXL];
          r_ie  <= cp0_wdata[SR_IE];
        end
        if (cp0_we && cp0_addr == REG_EPC) r_epc <= cp0_wdata & ~32'd3;
        // later assignment wins: an mtc0 SR in the same cycle as eret still ends with EXL clear
        if (EXLClr) r_exl <= 1'b0;
      end
    end
  end
endmodule
